// File: rtl/mux6_arbiter.sv
// Round-robin arbiter granting one of six requesters ownership of the 6-input mux select path.
// Optional hold limit enabled with `define ARB_HOLD_LIMIT_EN (forced release after MAX_HOLD cycles).
module mux6_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] REQ,
    output logic [5:0] GNT,
    output logic [2:0] SELECT,
    output logic       VALID,
    output logic       TOUT
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state_r;
    logic [2:0] last_r;
    logic [5:0] gnt_r;
    logic [2:0] select_r;
    logic       valid_r;
    logic       tout_r;
    logic [2:0] pick_s;
    logic       limit_s;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux6_arbiter: MAX_HOLD must be in 2..255");
    end

    // First requester after the last owner, wrapping modulo 6; the last owner ranks lowest.
    function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        logic [3:0] sum;
        logic [3:0] idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int off = 1; off <= 6; off++) begin
            sum = {1'b0, last} + 4'(off);
            idx = (sum >= 4'd6) ? (sum - 4'd6) : sum;
            if (!found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // Round-robin choice for the next arbitration slot.
    always_comb begin
        pick_s = rr_pick(REQ, last_r);
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_r;

    // Grant-length counter: cleared when a grant starts, counts every GRANT cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt_r <= 8'd0;
        end else if (state_r == IDLE) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end
    end

    assign limit_s = (hold_cnt_r == HOLD_LAST);
`else
    assign limit_s = 1'b0;
`endif

    // Arbiter state and registered outputs; a release always passes through one IDLE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            last_r   <= 3'd5;
            gnt_r    <= 6'd0;
            select_r <= 3'd0;
            valid_r  <= 1'b0;
            tout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tout_r <= 1'b0;
                    if (|REQ) begin
                        state_r  <= GRANT;
                        last_r   <= pick_s;
                        gnt_r    <= 6'd1 << pick_s;
                        select_r <= pick_s;
                        valid_r  <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        gnt_r    <= 6'd0;
                        select_r <= 3'd0;
                        valid_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    // last_r holds the current owner; a drop on the limit edge is a normal release.
                    if (!REQ[last_r] || limit_s) begin
                        state_r  <= IDLE;
                        gnt_r    <= 6'd0;
                        select_r <= 3'd0;
                        valid_r  <= 1'b0;
                        tout_r   <= REQ[last_r];
                    end else begin
                        state_r <= GRANT;
                        tout_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    gnt_r    <= 6'd0;
                    select_r <= 3'd0;
                    valid_r  <= 1'b0;
                    tout_r   <= 1'b0;
                end
            endcase
        end
    end

    assign GNT    = gnt_r;
    assign SELECT = select_r;
    assign VALID  = valid_r;
    assign TOUT   = tout_r;

endmodule
